// File: rtl/enc_blck_serializer_pkg.sv
// Shared constants, FSM state encoding and pointer-width helper for the
// encoder-side block serializer and its last-word detector.
package enc_blck_serializer_pkg;

  localparam int ENC_N        = 128;
  localparam int ENC_BUS_SIZE = 32;
  localparam int NWORDS       = ENC_N / ENC_BUS_SIZE;
  localparam int BUSdiv8      = ENC_BUS_SIZE / 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  // A single-word buffer still needs a 1-bit pointer to stay a legal vector.
  function automatic int ptr_width(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/enc_last_word_detect.sv
// Combinational check on a word-grouped byte-validity vector: flags the word at
// i_ptr as last when no higher word holds a valid byte, and flags all-zero validity.
module enc_last_word_detect
  import enc_blck_serializer_pkg::*;
#(
  parameter int P_NWORDS  = NWORDS,
  parameter int P_BUSDIV8 = BUSdiv8,
  parameter int P_PTR_W   = ptr_width(NWORDS)
) (
  input  logic [P_NWORDS*P_BUSDIV8-1:0] i_validity,
  input  logic [P_PTR_W-1:0]            i_ptr,
  output logic                          o_last,
  output logic                          o_zero
);

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    o_last = 1'b1;
    for (int k = 0; k < P_NWORDS; k++) begin
      if ((k > int'(i_ptr)) && (|i_validity[k*P_BUSDIV8 +: P_BUSDIV8])) begin
        o_last = 1'b0;
      end
    end
  end

  assign o_zero = ~|i_validity;

endmodule

// File: rtl/enc_blck_serializer.sv
// Captures one n-bit block (with byte validity) or tag and streams it LSB word
// first on a valid/ready bus. Define ENC_SER_OVERLAP_EN to accept the next load
// during the last-word handshake (back-to-back blocks without an idle cycle).
module enc_blck_serializer
  import enc_blck_serializer_pkg::*;
#(
  parameter int BUS_SIZE = ENC_BUS_SIZE,
  parameter int n        = ENC_N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [n-1:0]          blck_in,
  input  logic [n/8-1:0]        blck_in_validity,
  input  logic                  blck_in_load,
  input  logic [n-1:0]          tag_in,
  input  logic                  tag_load,
  output logic                  in_ready,
  output logic [BUS_SIZE-1:0]   dout,
  output logic [BUS_SIZE/8-1:0] dout_validity,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  busy
);

  localparam int L_NWORDS  = n / BUS_SIZE;
  localparam int L_BUSDIV8 = BUS_SIZE / 8;
  localparam int PTR_W     = ptr_width(L_NWORDS);

  ser_state_e           r_state, w_state_nxt;
  logic [PTR_W-1:0]     r_ptr, w_ptr_nxt;
  logic [n-1:0]         r_buf;
  logic [n/8-1:0]       r_bvalid;

  logic                 w_load, w_accept, w_hs, w_in_ready;
  logic                 w_last, w_load_zero;
  logic                 w_unused_buf_zero, w_unused_load_last;
  logic [n-1:0]         w_load_data;
  logic [n/8-1:0]       w_load_valid;
  logic [BUS_SIZE-1:0]  w_word;
  logic [L_BUSDIV8-1:0] w_word_vld;

  // A block strobe always wins; a tag is treated as fully valid.
  assign w_load       = blck_in_load | tag_load;
  assign w_load_data  = blck_in_load ? blck_in : tag_in;
  assign w_load_valid = blck_in_load ? blck_in_validity : '1;

  assign busy       = (r_state == SEND);
  assign dout_valid = busy;
  assign w_hs       = dout_valid & dout_ready;

`ifdef ENC_SER_OVERLAP_EN
  assign w_in_ready = (r_state == IDLE) | (w_hs & w_last);
`else
  assign w_in_ready = (r_state == IDLE);
`endif
  assign in_ready = w_in_ready;
  assign w_accept = w_in_ready & w_load;

  enc_last_word_detect #(
    .P_NWORDS (L_NWORDS),
    .P_BUSDIV8(L_BUSDIV8),
    .P_PTR_W  (PTR_W)
  ) u_out_chk (
    .i_validity(r_bvalid),
    .i_ptr     (r_ptr),
    .o_last    (w_last),
    .o_zero    (w_unused_buf_zero)
  );

  // Second instance only screens the incoming load for all-zero validity.
  enc_last_word_detect #(
    .P_NWORDS (L_NWORDS),
    .P_BUSDIV8(L_BUSDIV8),
    .P_PTR_W  (PTR_W)
  ) u_load_chk (
    .i_validity(w_load_valid),
    .i_ptr     ('0),
    .o_last    (w_unused_load_last),
    .o_zero    (w_load_zero)
  );

  always_comb begin
    w_word     = '0;
    w_word_vld = '0;
    for (int k = 0; k < L_NWORDS; k++) begin
      if (r_ptr == PTR_W'(k)) begin
        w_word     = r_buf[k*BUS_SIZE +: BUS_SIZE];
        w_word_vld = r_bvalid[k*L_BUSDIV8 +: L_BUSDIV8];
      end
    end
  end

  // Outputs are forced to zero outside SEND so stale buffer data never shows.
  assign dout          = busy ? w_word : '0;
  assign dout_validity = busy ? w_word_vld : '0;
  assign dout_last     = busy & w_last;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      IDLE: begin
        if (w_accept && !w_load_zero) begin
          w_state_nxt = SEND;
          w_ptr_nxt   = '0;
        end
      end
      SEND: begin
        if (w_hs) begin
          if (w_last) begin
            w_state_nxt = (w_accept && !w_load_zero) ? SEND : IDLE;
            w_ptr_nxt   = '0;
          end else begin
            w_ptr_nxt = r_ptr + PTR_W'(1);
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_bvalid <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_accept) r_bvalid <= w_load_valid;
    end
  end

  // NOTE: the data buffer is deliberately not reset; it is only observed in
  // SEND, which is entered solely through a fresh capture.
  always_ff @(posedge clk) begin
    if (w_accept) r_buf <= w_load_data;
  end

endmodule

// File: tb/tb_enc_blck_serializer.sv
// Self-checking bench for enc_blck_serializer: directed plan steps plus random
// blocks, checked against a word-list model built from the data and validity.
module tb_enc_blck_serializer;

  localparam int N   = 128;
  localparam int BUS = 32;

`ifdef ENC_SER_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   blck_in, tag_in;
  logic [N/8-1:0] blck_in_validity;
  logic           blck_in_load, tag_load;
  logic           in_ready;
  logic [BUS-1:0] dout;
  logic [3:0]     dout_validity;
  logic           dout_valid, dout_ready, dout_last, busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  v;
    logic        last;
  } exp_t;
  exp_t exp_q[$];

  enc_blck_serializer #(.BUS_SIZE(BUS), .n(N)) dut (
    .clk             (clk),
    .rst             (rst),
    .blck_in         (blck_in),
    .blck_in_validity(blck_in_validity),
    .blck_in_load    (blck_in_load),
    .tag_in          (tag_in),
    .tag_load        (tag_load),
    .in_ready        (in_ready),
    .dout            (dout),
    .dout_validity   (dout_validity),
    .dout_valid      (dout_valid),
    .dout_ready      (dout_ready),
    .dout_last       (dout_last),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: one word per 32-bit slice that holds any valid byte, LSB first;
  // the highest such word is the last one.
  task automatic build_exp(input logic [127:0] data, input logic [15:0] vld);
    exp_t e;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      if (vld[k*4 +: 4] != 4'h0) begin
        e.d    = data[k*32 +: 32];
        e.v    = vld[k*4 +: 4];
        e.last = 1'b0;
        exp_q.push_back(e);
      end
    end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
  endtask

  task automatic do_load(input logic [127:0] db, input logic [15:0] vb, input bit lb,
                         input logic [127:0] dt, input bit lt);
    check("in_ready_before_load", in_ready, 1'b1);
    blck_in = db; blck_in_validity = vb; blck_in_load = lb;
    tag_in = dt; tag_load = lt;
    if (lb) build_exp(db, vb);
    else    build_exp(dt, 16'hFFFF);
    tick();
    blck_in_load = 1'b0; tag_load = 1'b0;
  endtask

  // Checks expected words [first, stop) starting from the word currently shown;
  // optionally holds dout_ready low for stall_cycles on word stall_word.
  task automatic check_words(input int first, input int stop, input int stall_word,
                             input int stall_cycles);
    for (int i = first; i < stop; i++) begin
      if (i == stall_word && stall_cycles > 0) begin
        dout_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          check($sformatf("stall_valid_w%0d", i), dout_valid, 1'b1);
          check($sformatf("stall_dout_w%0d", i), dout, exp_q[i].d);
          check($sformatf("stall_vld_w%0d", i), dout_validity, exp_q[i].v);
          check($sformatf("stall_last_w%0d", i), dout_last, exp_q[i].last);
          tick();
        end
        dout_ready = 1'b1;
      end
      check($sformatf("valid_w%0d", i), dout_valid, 1'b1);
      check($sformatf("busy_w%0d", i), busy, 1'b1);
      check($sformatf("dout_w%0d", i), dout, exp_q[i].d);
      check($sformatf("vld_w%0d", i), dout_validity, exp_q[i].v);
      check($sformatf("last_w%0d", i), dout_last, exp_q[i].last);
      if (!exp_q[i].last) check($sformatf("in_ready_w%0d", i), in_ready, 1'b0);
      tick();
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, dout_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  localparam logic [127:0] BLK_A = 128'h33221100_77665544_BBAA9988_FFEEDDCC;
  localparam logic [127:0] BLK_B = 128'hDEADBEEF_CAFEF00D_01020304_A5A55A5A;
  localparam logic [127:0] TAG_T = 128'h0123456789ABCDEF0123456789ABCDEF;

  initial begin
    logic [127:0] rd, rt;
    logic [16:0]  len_mask;
    logic [15:0]  rv;
    int           len, sw, sc;
    bit           lb, lt;

    rst = 1'b1; dout_ready = 1'b1;
    blck_in = '0; blck_in_validity = '0; blck_in_load = 1'b0;
    tag_in = '0; tag_load = 1'b0;
    tick(); tick();
    check("rst_valid", dout_valid, 1'b0);
    check("rst_last", dout_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_dout", dout, 32'h0);
    check("rst_vld", dout_validity, 4'h0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    tick();
    check_idle("post_rst");

    // Full block, words LSB first, in_ready back five cycles after the load.
    do_load(BLK_A, 16'hFFFF, 1'b1, '0, 1'b0);
    check("full_w0_literal", dout, 32'hFFEEDDCC);
    check_words(0, exp_q.size(), -1, 0);
    check_idle("full_end");

    // Partial block: two words, second with validity 0x3.
    do_load(BLK_A, 16'h003F, 1'b1, '0, 1'b0);
    check("partial_nwords", exp_q.size(), 2);
    check_words(0, exp_q.size(), -1, 0);
    check_idle("partial_end");

    // Backpressure on word 1 for three cycles.
    do_load(BLK_A, 16'hFFFF, 1'b1, '0, 1'b0);
    check_words(0, exp_q.size(), 1, 3);
    check_idle("bp_end");

    // Tag, then a collision where the block must win.
    do_load('0, 16'h0000, 1'b0, TAG_T, 1'b1);
    check_words(0, exp_q.size(), -1, 0);
    check_idle("tag_end");
    do_load(BLK_B, 16'h0FFF, 1'b1, TAG_T, 1'b1);
    check_words(0, exp_q.size(), -1, 0);
    check_idle("collide_end");

    // Zero-validity load is consumed without emitting anything.
    do_load(BLK_A, 16'h0000, 1'b1, '0, 1'b0);
    check_idle("zero_vld");
    tick();
    check_idle("zero_vld_next");

    // A load strobed mid-SEND is ignored.
    do_load(BLK_A, 16'hFFFF, 1'b1, '0, 1'b0);
    check_words(0, 1, -1, 0);
    blck_in = BLK_B; blck_in_validity = 16'hFFFF; blck_in_load = 1'b1;
    check("midsend_in_ready", in_ready, 1'b0);
    check_words(1, 2, -1, 0);
    blck_in_load = 1'b0;
    check_words(2, exp_q.size(), -1, 0);
    check_idle("midsend_end");

    // Reset after two words discards the rest.
    do_load(BLK_A, 16'hFFFF, 1'b1, '0, 1'b0);
    check_words(0, 2, -1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midrst");
    check("midrst_dout", dout, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_stale", dout_valid, 1'b0);
    end

    // Load during the last-word handshake.
    do_load(BLK_A, 16'hFFFF, 1'b1, '0, 1'b0);
    check_words(0, 3, -1, 0);
    blck_in = BLK_B; blck_in_validity = 16'h00FF; blck_in_load = 1'b1;
    check("overlap_in_ready", in_ready, OVL);
    check_words(3, 4, -1, 0);
    blck_in_load = 1'b0;
`ifdef ENC_SER_OVERLAP_EN
    build_exp(BLK_B, 16'h00FF);
    check_words(0, exp_q.size(), -1, 0);
    check_idle("overlap_end");
`else
    check_idle("overlap_ignored");
    tick();
    check_idle("overlap_ignored_next");
`endif

    // Random blocks and tags with random contiguous lengths and stalls.
    for (int it = 0; it < 12; it++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      rt = {$urandom, $urandom, $urandom, $urandom};
      len = $urandom_range(0, 16);
      len_mask = (17'd1 << len) - 17'd1;
      rv = len_mask[15:0];
      lt = ($urandom_range(0, 2) == 0);
      lb = !lt || ($urandom_range(0, 1) == 1);
      sw = $urandom_range(0, 3);
      sc = $urandom_range(0, 3);
      do_load(rd, rv, lb, rt, lt);
      check_words(0, exp_q.size(), sw, sc);
      check_idle($sformatf("rand%0d_end", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/enc_blck_serializer.md
Name: enc_blck_serializer

Overview:
- Sits directly downstream of the mode datapath, between it and the output encoder/FIFO.
- Captures either one n-bit digested block with its per-byte validity, or the n-bit tag.
- Serializes the captured data into BUS_SIZE-bit words on a valid/ready stream.
- Emits only words that carry valid bytes and flags the final word of each block.

Parameters:
- BUS_SIZE, 32, output word width in bits; must divide n and be a multiple of 8.
- n, 128, block/tag width in bits.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset.
- blck_in, input, n, digested block from the shadow core (to_enc_bundle_blck_out).
- blck_in_validity, input, n/8, per-byte validity of blck_in; bit i covers byte i.
- blck_in_load, input, 1, capture strobe for blck_in.
- tag_in, input, n, tag from Clyde (to_enc_tag).
- tag_load, input, 1, capture strobe for tag_in.
- in_ready, output, 1, block can accept a load this cycle.
- dout, output, BUS_SIZE, output word.
- dout_validity, output, BUS_SIZE/8, byte validity of dout.
- dout_valid, output, 1, dout holds a word.
- dout_ready, input, 1, consumer accepts dout.
- dout_last, output, 1, dout is the final word of the current block or tag.
- busy, output, 1, the serializer is in the SEND state.

Interface rule: one clock; reset is synchronous and active-high (ports clk, rst).

Behaviour:
- Reset values: dout_valid=0, dout_last=0, busy=0, dout=0, dout_validity=0, in_ready=1, word pointer=0, state=IDLE.
- Reset applied mid-SEND discards the buffer; no further words are emitted.
- Constants: NWORDS=n/BUS_SIZE; pointer width=clog2(NWORDS); pointer never exceeds NWORDS-1.
- in_ready = (state==IDLE).
- Load accepted when in_ready & (blck_in_load | tag_load).
  - blck_in_load wins over tag_load; a simultaneous tag is dropped.
  - A tag capture sets buffer validity to all ones.
- Word order: LSB first. Word k = buf[k*BUS_SIZE +: BUS_SIZE], with validity bvalid[k*BUS_SIZE/8 +: BUS_SIZE/8].
- Validity is contiguous from byte 0 (padding/partial last block). Non-contiguous validity is undefined input.
- State IDLE:
  - Load with nonzero validity -> SEND, pointer=0. Registered output, so dout_valid rises the cycle after the load.
  - Load with all-zero validity -> accepted and consumed; stays IDLE; no word emitted.
- State SEND:
  - dout, dout_validity and dout_last are held stable while dout_valid & !dout_ready.
  - dout_last=1 when the current word is NWORDS-1 or all higher validity bits are zero.
  - On handshake (dout_valid & dout_ready):
    - if dout_last -> IDLE, dout_valid=0 next cycle;
    - otherwise pointer+1 and the next word is presented the next cycle.
- Throughput: one word per cycle with dout_ready held high.
  - Full block: load at cycle t, words at t+1..t+4 (n=128, BUS=32), in_ready high again at t+5.
- Loads during SEND: in_ready=0 and the load is ignored. The controller must not strobe then.

Optional Feature:
- Macro: ENC_SER_OVERLAP_EN.
- Defined:
  - in_ready is also high in SEND during the handshake cycle of the last word.
  - A load in that cycle is captured, pointer resets to 0, and SEND continues with no idle bubble.
  - A zero-validity load in that cycle -> IDLE.
- Undefined: behaviour exactly as above; there is always one IDLE cycle between blocks.

Decomposition:
- Shared mode package holds:
  - NWORDS and BUSdiv8 localparams;
  - the 1-bit state encoding (IDLE=0, SEND=1);
  - the clog2 helper for the pointer width.
- One natural sub-module: enc_last_word_detect.
  - Combinational.
  - Inputs: validity vector and pointer.
  - Outputs: dout_last and the zero-validity flag.
  - Reused by the decoder-side block builder for its symmetric check.
- All other logic stays inline.

Test Plan:
- Full block: blck_in=0x33221100_77665544_BBAA9988_FFEEDDCC, validity=0xFFFF, dout_ready=1 -> dout sequence 0xFFEEDDCC, 0xBBAA9988, 0x77665544, 0x33221100, each with validity 0xF; last only on the 4th word; in_ready returns after 5 cycles.
- Partial block: validity=0x003F -> 2 words; second word has dout_validity=0x3 and dout_last=1; no third word.
- Backpressure: dout_ready low for 3 cycles on word 1 -> dout/validity/last stable, pointer unchanged, then the sequence resumes in order.
- Tag and collision: tag_load with tag=0x0123...CDEF -> 4 words, all validity 0xF. Simultaneous blck_in_load & tag_load -> block captured, tag dropped.
- Zero validity and reset: zero-validity load -> no dout_valid, in_ready high the next cycle. rst asserted after word 2 -> dout_valid=0 the next cycle, in_ready=1, no stale words afterwards.
- ENC_SER_OVERLAP_EN: load during the last-word handshake -> next block's word 0 appears the next cycle with no bubble. Without the macro the same load is ignored.
